pipelined_carry_select_adder: RTL
=================================

// Module: pipelined_carry_select_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor for the datapath lab blocks.
//  Operands are split into WIDTH/BLOCK blocks. Each block precomputes sums for carry-in 0 and 1.
//  Each pipeline stage then selects one block using the registered carry from the stage before.
//  Valid/ready streaming interface; throughput of one operation per cycle; adds subtract and signed overflow.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of BLOCK
//  BLOCK  8   bits per carry-select block; >= 2; NBLK = WIDTH/BLOCK = pipeline depth
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in; ignored when sub=1
//  sub        in   1      1: A-B (two's complement), 0: A+B+cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow of the result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, sum, cout and ovf clear to 0; in-flight beats are discarded.
//    in_ready=1 once rst_n=1.
//  - Operand prep at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
//  - Stage k (k=0..NBLK-1) holds a valid bit, the remaining operand slices, the selected low sum bits and carry c_k.
//    Block k: s0 = a_k+b_k+0 and s1 = a_k+b_k+1, each BLOCK+1 bits.
//    Select by c_k: sum_k = sel[BLOCK-1:0], c_{k+1} = sel[BLOCK].
//  - Latency is exactly NBLK cycles: a beat accepted at edge t has out_valid=1 after edge t+NBLK when there is no stall.
//  - Stall: stall = out_valid & ~out_ready; in_ready = ~stall. On stall every stage holds its contents.
//    Bubbles are not collapsed.
//  - Transfer occurs only on in_valid&in_ready (input) or out_valid&out_ready (output).
//    Ordering is strictly FIFO; no beat is dropped or duplicated.
//  - in_valid=0 with no stall: a bubble (valid=0) enters stage 0.
//    sum/cout/ovf are don't-care while out_valid=0, but must hold stable while out_valid=1 and stalled.
//  - Simultaneous accept and emit in one cycle is legal and yields full throughput.
//  - cout = c_NBLK.
//  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), computed on the unsaturated sum.
//    The required MSBs are carried down the pipeline.
//  - Wrap-around: the result is modulo 2^WIDTH unless saturation is compiled in.
//  - Illegal parameters (WIDTH%BLOCK != 0, BLOCK<2) must fail elaboration via a generate-time check.
// CONFIGURATION
//  CSA_SATURATE_EN defined: when ovf=1, the final stage replaces sum with a signed clamp.
//    Clamp is {0,{WIDTH-1{1}}} if a[MSB]=0, else {1,{WIDTH-1{0}}}; ovf is still reported as 1.
//    cout is unchanged; latency is unchanged.
//  Not defined: no clamp logic; sum always wraps modulo 2^WIDTH.
// TESTING (WIDTH=16, BLOCK=4, NBLK=4 unless stated)
//  1 a=4B37 b=243B cin=0 sub=0, out_ready=1 -> after 4 cycles out_valid=1, sum=6F72, cout=0, ovf=0.
//  2 a=FFFF b=0001 cin=0 -> sum=0000, cout=1, ovf=0.
//    a=7FFF b=0001 -> sum=8000, ovf=1 (CSA_SATURATE_EN: sum=7FFF, ovf=1).
//  3 sub=1: a=0003 b=0005 -> sum=FFFE, cout=0, ovf=0.
//    sub=1: a=8000 b=0001 -> sum=7FFF, ovf=1 (sat: 8000).
//  4 Eight back-to-back beats with out_ready held 0 for 3 cycles mid-stream.
//    -> in_ready=0 exactly during the stall, outputs stable, all eight results in order, none lost.
//  5 Assert rst_n=0 for one cycle with 3 beats in flight, asynchronously mid-cycle.
//    -> out_valid=0 immediately, then no stale results; the next beat emerges 4 cycles after accept.
//  6 WIDTH=32, BLOCK=8: 1000 random beats, random in_valid/out_ready.
//    -> every result equals the reference model {cout,sum}=a+b_eff+c0; latency 4 when unstalled.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: one carry-select block per stage, valid/ready stream.
// Optional build macro CSA_SATURATE_EN clamps the result to the signed range on overflow.
module pipelined_carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || BLOCK < 2) begin : g_bad_params
    $error("WIDTH must be a multiple of BLOCK and BLOCK must be >= 2");
  end

  // stage k holds operands, low sum bits of blocks < k and carry c_k
  logic             r_vld [NBLK];
  logic [WIDTH-1:0] r_a   [NBLK];
  logic [WIDTH-1:0] r_b   [NBLK];
  logic [WIDTH-1:0] r_s   [NBLK];
  logic             r_c   [NBLK];

  logic             r_ovld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sn [NBLK];
  logic             w_cn [NBLK];
  logic [BLOCK:0]   w_s0;
  logic [BLOCK:0]   w_s1;
  logic [BLOCK:0]   w_sel;
  logic             w_stall;
  logic             w_en;
  logic             w_amsb;
  logic             w_bmsb;
  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;
  logic [WIDTH-1:0] w_fsum;

  assign w_stall  = r_ovld & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  // block k: both carry-in sums, picked by the carry held in stage k
  always_comb begin
    w_s0  = '0;
    w_s1  = '0;
    w_sel = '0;
    for (int k = 0; k < NBLK; k++) begin
      w_s0  = {1'b0, r_a[k][k*BLOCK +: BLOCK]}
            + {1'b0, r_b[k][k*BLOCK +: BLOCK]};
      w_s1  = w_s0 + (BLOCK+1)'(1);
      w_sel = r_c[k] ? w_s1 : w_s0;
      w_sn[k] = r_s[k];
      w_sn[k][k*BLOCK +: BLOCK] = w_sel[BLOCK-1:0];
      w_cn[k] = w_sel[BLOCK];
    end
  end

  assign w_amsb = r_a[NBLK-1][WIDTH-1];
  assign w_bmsb = r_b[NBLK-1][WIDTH-1];
  assign w_raw  = w_sn[NBLK-1];
  assign w_ovf  = (w_amsb == w_bmsb) & (w_raw[WIDTH-1] != w_amsb);

`ifdef CSA_SATURATE_EN
  assign w_fsum = !w_ovf ? w_raw :
                  w_amsb ? {1'b1, {(WIDTH-1){1'b0}}} :
                           {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_fsum = w_raw;
`endif

  // advance every stage together unless the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovld <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      r_a[0]   <= a;
      r_b[0]   <= sub ? ~b : b;
      r_s[0]   <= '0;
      r_c[0]   <= sub ? 1'b1 : cin;
      for (int k = 1; k < NBLK; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_s[k]   <= w_sn[k-1];
        r_c[k]   <= w_cn[k-1];
      end
      r_ovld <= r_vld[NBLK-1];
      r_sum  <= w_fsum;
      r_cout <= w_cn[NBLK-1];
      r_ovf  <= w_ovf;
    end
  end

  assign out_valid = r_ovld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
